// File: rtl/apb_requester.sv
`default_nettype none
// ============================================================================
//  Module      : apb_requester
//  Description : APB4 requester. It takes one transfer at a time from a
//                valid/ready user port and runs the SETUP and ACCESS phases
//                on the APB bus. It returns read data and an error flag on
//                a one-cycle response pulse.
//
//  Ports       : pclk, preset_n           clock, async active-low reset
//                req_valid/req_ready      user request handshake
//                req_write/addr/wdata/
//                req_strb/req_prot        request fields
//                rsp_valid/rdata/error    one-cycle completion response
//                paddr/pprot/psel/penable/
//                pwrite/pwdata/pstrb      APB request outputs (registered)
//                pready/prdata/pslverr    APB completer response
//
//  Options     : APB_TIMEOUT_EN - when defined, ACCESS aborts with an
//                error response after TIMEOUT_CYCLES cycles without pready.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_requester #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int BYTES_PER_WORD = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      pclk,
    input  logic                      preset_n,
    // user request port
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [BYTES_PER_WORD-1:0] req_strb,
    input  logic [2:0]                req_prot,
    // user response port
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_error,
    // APB requester side
    output logic [ADDR_WIDTH-1:0]     paddr,
    output logic [2:0]                pprot,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [BYTES_PER_WORD-1:0] pstrb,
    input  logic                      pready,
    input  logic [DATA_WIDTH-1:0]     prdata,
    input  logic                      pslverr
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
        $error("apb_requester: DATA_WIDTH must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_requester: TIMEOUT_CYCLES must be >= 1");
    end

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                    r_state;
    logic [ADDR_WIDTH-1:0]     r_paddr;
    logic [2:0]                r_pprot;
    logic                      r_psel;
    logic                      r_penable;
    logic                      r_pwrite;
    logic [DATA_WIDTH-1:0]     r_pwdata;
    logic [BYTES_PER_WORD-1:0] r_pstrb;
    logic                      r_rsp_valid;
    logic [DATA_WIDTH-1:0]     r_rsp_rdata;
    logic                      r_rsp_error;

`ifdef APB_TIMEOUT_EN
    // The counter only needs to reach TIMEOUT_CYCLES-1: the abort decision
    // is taken in the ACCESS cycle that would bring it to TIMEOUT_CYCLES.
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_tmo_cnt;
`endif

    // Ready is derived directly from the state, so a new request can be
    // taken in the same cycle the previous response is presented.
    assign req_ready = (r_state == S_IDLE);

    // ------------------------------------------------------------------
    // Transfer sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state     <= S_IDLE;
            r_paddr     <= '0;
            r_pprot     <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
        end else begin
            // Response is a single-cycle pulse; completion re-asserts it.
            r_rsp_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_state  <= S_SETUP;
                        r_psel   <= 1'b1;
                        r_paddr  <= req_addr;
                        r_pprot  <= req_prot;
                        r_pwrite <= req_write;
                        // Reads carry no write data or strobes on the bus.
                        r_pwdata <= req_write ? req_wdata : '0;
                        r_pstrb  <= req_write ? req_strb  : '0;
                    end
                end

                S_SETUP: begin
                    r_state   <= S_ACCESS;
                    r_penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                end

                S_ACCESS: begin
                    // pready is tested first so that a response arriving
                    // on the abort cycle completes normally.
                    if (pready) begin
                        r_state     <= S_IDLE;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= pslverr;
                        r_rsp_rdata <= r_pwrite ? '0 : prdata;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (r_tmo_cnt == c_CNT_LAST) begin
                        r_state     <= S_IDLE;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b1;
                        r_rsp_rdata <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign paddr     = r_paddr;
    assign pprot     = r_pprot;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;
    assign pstrb     = r_pstrb;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;

endmodule
`default_nettype wire

// File: tb/tb_apb_requester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_requester
//  Description : Directed self-checking bench for apb_requester. Each task
//                drives one scenario and compares outputs against
//                hand-computed values, sampling 1 time unit after the
//                rising clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_apb_requester;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int BW = DW / 8;

    logic          pclk;
    logic          preset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_strb;
    logic [2:0]    req_prot;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic [AW-1:0] paddr;
    logic [2:0]    pprot;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [BW-1:0] pstrb;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    logic [3:0]    ctrl;
    int            n_pass;
    int            n_total;

    assign ctrl = {psel, penable, req_ready, rsp_valid};

    apb_requester #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .BYTES_PER_WORD (BW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_prot  (req_prot),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .paddr     (paddr),
        .pprot     (pprot),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive_req(input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [BW-1:0] s,
                             input logic [2:0] p);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
        req_prot  = p;
    endtask

    task automatic test_reset();
        n_total++;
        if ({ctrl, pwrite, rsp_error, pprot, pstrb} !== {4'b0010, 1'b0, 1'b0, 3'b0, 4'h0})
            $display("FAIL reset_ctrl: got %b expected %b",
                     {ctrl, pwrite, rsp_error, pprot, pstrb}, {4'b0010, 1'b0, 1'b0, 3'b0, 4'h0});
        else n_pass++;
        n_total++;
        if ({paddr, pwdata, rsp_rdata} !== '0)
            $display("FAIL reset_data: got %h expected 0", {paddr, pwdata, rsp_rdata});
        else n_pass++;
    endtask

    task automatic test_write();
        pready = 1'b1; pslverr = 1'b0; prdata = 32'hFFFF_FFFF;
        drive_req(1'b1, 10'h004, 32'hDEAD_BEEF, 4'hF, 3'b010);
        tick(); req_valid = 1'b0;
        n_total++;
        if (ctrl !== 4'b1000) $display("FAIL wr_setup_ctrl: got %b expected %b", ctrl, 4'b1000);
        else n_pass++;
        n_total++;
        if ({paddr, pwrite, pwdata, pstrb, pprot} !== {10'h004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010})
            $display("FAIL wr_setup_fields: got %h expected %h", {paddr, pwrite, pwdata, pstrb, pprot},
                     {10'h004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010});
        else n_pass++;
        tick();
        n_total++;
        if (ctrl !== 4'b1100) $display("FAIL wr_access_ctrl: got %b expected %b", ctrl, 4'b1100);
        else n_pass++;
        tick();
        n_total++;
        if ({ctrl, rsp_error, rsp_rdata} !== {4'b0011, 1'b0, 32'h0})
            $display("FAIL wr_resp: got %h expected %h", {ctrl, rsp_error, rsp_rdata}, {4'b0011, 1'b0, 32'h0});
        else n_pass++;
        tick();
        n_total++;
        if ({rsp_valid, paddr} !== {1'b0, 10'h004})
            $display("FAIL wr_idle_hold: got %h expected %h", {rsp_valid, paddr}, {1'b0, 10'h004});
        else n_pass++;
    endtask

    task automatic test_read_wait();
        pready = 1'b0; prdata = 32'hBAD0_BAD0;
        drive_req(1'b0, 10'h010, 32'hCAFE_F00D, 4'hF, 3'b000);
        tick(); req_valid = 1'b0;
        n_total++;
        if ({ctrl, pwrite, pstrb, pwdata} !== {4'b1000, 1'b0, 4'h0, 32'h0})
            $display("FAIL rd_setup: got %h expected %h", {ctrl, pwrite, pstrb, pwdata}, {4'b1000, 1'b0, 4'h0, 32'h0});
        else n_pass++;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if ({ctrl, paddr} !== {4'b1100, 10'h010})
                $display("FAIL rd_access_%0d: got %h expected %h", i, {ctrl, paddr}, {4'b1100, 10'h010});
            else n_pass++;
            if (i == 3) begin
                pready = 1'b1;
                prdata = 32'h1234_5678;
            end
            tick();
        end
        pready = 1'b0;
        n_total++;
        if ({ctrl, rsp_error, rsp_rdata} !== {4'b0011, 1'b0, 32'h1234_5678})
            $display("FAIL rd_resp: got %h expected %h", {ctrl, rsp_error, rsp_rdata}, {4'b0011, 1'b0, 32'h1234_5678});
        else n_pass++;
        tick();
        n_total++;
        if ({rsp_valid, rsp_rdata} !== {1'b0, 32'h1234_5678})
            $display("FAIL rd_hold: got %h expected %h", {rsp_valid, rsp_rdata}, {1'b0, 32'h1234_5678});
        else n_pass++;
    endtask

    task automatic test_error();
        pready = 1'b1; pslverr = 1'b1; prdata = 32'h0000_00EE;
        drive_req(1'b0, 10'h020, 32'h0, 4'h0, 3'b001);
        tick(); req_valid = 1'b0;
        tick();
        tick();
        n_total++;
        if ({rsp_valid, rsp_error, rsp_rdata} !== {1'b1, 1'b1, 32'h0000_00EE})
            $display("FAIL err_resp: got %h expected %h", {rsp_valid, rsp_error, rsp_rdata}, {1'b1, 1'b1, 32'h0000_00EE});
        else n_pass++;
        pslverr = 1'b0;
        tick();
        n_total++;
        if ({rsp_valid, rsp_error} !== 2'b01)
            $display("FAIL err_hold: got %b expected %b", {rsp_valid, rsp_error}, 2'b01);
        else n_pass++;
        drive_req(1'b1, 10'h024, 32'h0000_0001, 4'h3, 3'b000);
        tick(); req_valid = 1'b0;
        n_total++;
        if (pstrb !== 4'h3) $display("FAIL err_wr_strb: got %h expected %h", pstrb, 4'h3);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if ({rsp_valid, rsp_error, rsp_rdata} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL err_clear: got %h expected %h", {rsp_valid, rsp_error, rsp_rdata}, {1'b1, 1'b0, 32'h0});
        else n_pass++;
        pready = 1'b0;
    endtask

    task automatic test_back_to_back();
        pready = 1'b1; pslverr = 1'b0;
        drive_req(1'b1, 10'h100, 32'h1111_1111, 4'hF, 3'b000);
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL b2b_ready0: got %b expected 1", req_ready);
        else n_pass++;
        tick();
        n_total++;
        if ({ctrl, paddr} !== {4'b1000, 10'h100})
            $display("FAIL b2b_setup1: got %h expected %h", {ctrl, paddr}, {4'b1000, 10'h100});
        else n_pass++;
        // next request presented while the first is in flight
        req_addr = 10'h104; req_wdata = 32'h2222_2222;
        tick();
        n_total++;
        if ({ctrl, paddr, pwdata} !== {4'b1100, 10'h100, 32'h1111_1111})
            $display("FAIL b2b_access1: got %h expected %h", {ctrl, paddr, pwdata}, {4'b1100, 10'h100, 32'h1111_1111});
        else n_pass++;
        tick();
        n_total++;
        if ({ctrl, paddr} !== {4'b0011, 10'h100})
            $display("FAIL b2b_resp1: got %h expected %h", {ctrl, paddr}, {4'b0011, 10'h100});
        else n_pass++;
        tick(); req_valid = 1'b0;
        n_total++;
        if ({ctrl, paddr, pwdata} !== {4'b1000, 10'h104, 32'h2222_2222})
            $display("FAIL b2b_setup2: got %h expected %h", {ctrl, paddr, pwdata}, {4'b1000, 10'h104, 32'h2222_2222});
        else n_pass++;
        tick();
        n_total++;
        if (ctrl !== 4'b1100) $display("FAIL b2b_access2: got %b expected %b", ctrl, 4'b1100);
        else n_pass++;
        tick();
        n_total++;
        if (ctrl !== 4'b0011) $display("FAIL b2b_resp2: got %b expected %b", ctrl, 4'b0011);
        else n_pass++;
        tick();
        n_total++;
        if (ctrl !== 4'b0010) $display("FAIL b2b_no_dup: got %b expected %b", ctrl, 4'b0010);
        else n_pass++;
        pready = 1'b0;
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        pready = 1'b0; prdata = 32'hFFFF_FFFF; pslverr = 1'b0;
        drive_req(1'b0, 10'h040, 32'h0, 4'h0, 3'b000);
        tick(); req_valid = 1'b0;
        tick();
        n = 0;
        while (psel && penable && n < 40) begin
            n++;
            tick();
        end
        n_total++;
        if (n !== 16) $display("FAIL tmo_cycles: got %0d expected 16", n);
        else n_pass++;
        n_total++;
        if ({ctrl, rsp_error, rsp_rdata} !== {4'b0011, 1'b1, 32'h0})
            $display("FAIL tmo_resp: got %h expected %h", {ctrl, rsp_error, rsp_rdata}, {4'b0011, 1'b1, 32'h0});
        else n_pass++;
        // pready on the final allowed cycle completes normally
        drive_req(1'b0, 10'h044, 32'h0, 4'h0, 3'b000);
        tick(); req_valid = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                pready = 1'b1;
                prdata = 32'hA5A5_A5A5;
            end
            tick();
        end
        pready = 1'b0;
        n_total++;
        if ({rsp_valid, rsp_error, rsp_rdata} !== {1'b1, 1'b0, 32'hA5A5_A5A5})
            $display("FAIL tmo_edge_win: got %h expected %h", {rsp_valid, rsp_error, rsp_rdata}, {1'b1, 1'b0, 32'hA5A5_A5A5});
        else n_pass++;
    endtask
`else
    task automatic test_no_timeout();
        int bad;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        drive_req(1'b0, 10'h030, 32'h0, 4'h0, 3'b000);
        tick(); req_valid = 1'b0;
        tick();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (ctrl !== 4'b1100) bad++;
            tick();
        end
        n_total++;
        if (bad !== 0) $display("FAIL wait_long: got %0d bad cycles expected 0", bad);
        else n_pass++;
        pready = 1'b1; prdata = 32'h0000_0055;
        tick();
        pready = 1'b0;
        n_total++;
        if ({ctrl, rsp_error, rsp_rdata} !== {4'b0011, 1'b0, 32'h0000_0055})
            $display("FAIL wait_long_resp: got %h expected %h", {ctrl, rsp_error, rsp_rdata}, {4'b0011, 1'b0, 32'h0000_0055});
        else n_pass++;
    endtask
`endif

    task automatic test_reset_mid();
        int bad;
        pready = 1'b0; prdata = 32'h0; pslverr = 1'b0;
        drive_req(1'b1, 10'h050, 32'h7777_7777, 4'hF, 3'b111);
        tick(); req_valid = 1'b0;
        tick();
        tick();
        #2 preset_n = 1'b0;
        #1;
        n_total++;
        if ({ctrl, pwrite, rsp_error, pprot, pstrb} !== {4'b0010, 1'b0, 1'b0, 3'b0, 4'h0})
            $display("FAIL rst_mid_ctrl: got %b expected %b",
                     {ctrl, pwrite, rsp_error, pprot, pstrb}, {4'b0010, 1'b0, 1'b0, 3'b0, 4'h0});
        else n_pass++;
        n_total++;
        if ({paddr, pwdata, rsp_rdata} !== '0)
            $display("FAIL rst_mid_data: got %h expected 0", {paddr, pwdata, rsp_rdata});
        else n_pass++;
        #2 preset_n = 1'b1;
        pready = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ctrl !== 4'b0010) bad++;
        end
        pready = 1'b0;
        n_total++;
        if (bad !== 0) $display("FAIL rst_mid_quiet: got %0d bad cycles expected 0", bad);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        preset_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_strb = '0; req_prot = '0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        tick();
        tick();
        preset_n = 1'b1;
        tick();
        test_reset();
        test_write();
        test_read_wait();
        test_error();
        test_back_to_back();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
